// File: rtl/timer_counter_pkg.sv
// ---------------------------------------------------------------------------
// timer_counter_pkg
// Shared constants for the CPU bus peripherals: CP0 exception codes plus the
// timer's register map, CTRL layout, MODE codes and FSM state encoding.
// ---------------------------------------------------------------------------
package timer_counter_pkg;

   // CP0 Cause.ExcCode values
   localparam int unsigned EXCCODE_W = 5;
   localparam logic [EXCCODE_W-1:0] EXCCODE_INT     = 5'd0;
   localparam logic [EXCCODE_W-1:0] EXCCODE_ADEL    = 5'd4;
   localparam logic [EXCCODE_W-1:0] EXCCODE_ADES    = 5'd5;
   localparam logic [EXCCODE_W-1:0] EXCCODE_SYSCALL = 5'd8;
   localparam logic [EXCCODE_W-1:0] EXCCODE_RI      = 5'd10;
   localparam logic [EXCCODE_W-1:0] EXCCODE_OV      = 5'd12;

   // Bus and datapath widths
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 2;
   localparam int unsigned BE_W    = DATA_W / 8;
   localparam int unsigned PRESC_W = 16;
   localparam int unsigned CTRL_W  = 4;

   // Register word offsets (byte address [3:2])
   localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd0;
   localparam logic [ADDR_W-1:0] ADDR_PRESET = 2'd1;
   localparam logic [ADDR_W-1:0] ADDR_COUNT  = 2'd2;
   localparam logic [ADDR_W-1:0] ADDR_RSVD   = 2'd3;

   // Timer modes; both 1x codes behave as one-shot
   typedef enum logic [1:0] {
      MODE_ONESHOT   = 2'b00,
      MODE_RELOAD    = 2'b01,
      MODE_ONESHOT_2 = 2'b10,
      MODE_ONESHOT_3 = 2'b11
   } mode_e;

   // CTRL register: [3]=IM, [2:1]=MODE, [0]=EN
   typedef struct packed {
      logic  im;
      mode_e mode;
      logic  en;
   } ctrl_t;

   // Counter FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_e;

   // Apply a byte-masked store to a 32-bit register value
   function automatic logic [DATA_W-1:0] byte_merge(
      input logic [DATA_W-1:0] old_val,
      input logic [DATA_W-1:0] new_val,
      input logic [BE_W-1:0]   be
   );
      logic [DATA_W-1:0] res;
      res = old_val;
      for (int k = 0; k < int'(BE_W); k++) begin
         if (be[k]) res[8*k +: 8] = new_val[8*k +: 8];
      end
      return res;
   endfunction

endpackage : timer_counter_pkg

// File: rtl/timer_counter.sv
// ---------------------------------------------------------------------------
// timer_counter
// Memory-mapped down-counting timer with prescaler, one-shot / auto-reload
// modes and a maskable interrupt to the CP0 HWInt input.
//
// Ports
//   clk     system clock, all state changes on its rising edge
//   reset   asynchronous active-low reset
//   sel     chip select from the bus bridge
//   addr    word index: 0=CTRL, 1=PRESET, 2=COUNT, 3=reserved
//   we      write strobe (qualified by sel)
//   byteen  per-byte write enables
//   wdata   write data
//   rdata   combinational read data (0 when deselected or reserved)
//   irq     interrupt request = IM & irq_flag
// ---------------------------------------------------------------------------
module timer_counter
   import timer_counter_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sel,
   input  logic [ADDR_W-1:0] addr,
   input  logic              we,
   input  logic [BE_W-1:0]   byteen,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              irq
);

   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESCALE - 1);

   ctrl_t               ctrl;
   logic [DATA_W-1:0]   preset;
   logic [DATA_W-1:0]   count;
   logic [PRESC_W-1:0]  presc;
   logic                irq_flag;
   state_e              state;

   logic                wr_ctrl_c;
   logic                wr_preset_c;

   // Bus write decode; COUNT and the reserved word have no write path
   assign wr_ctrl_c   = sel & we & (addr == ADDR_CTRL);
   assign wr_preset_c = sel & we & (addr == ADDR_PRESET);

   // Registers and counter FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl     <= '0;
         preset   <= '0;
         count    <= '0;
         presc    <= '0;
         irq_flag <= 1'b0;
         state    <= ST_IDLE;
      end else begin
         if (wr_preset_c) begin
            preset <= byte_merge(preset, wdata, byteen);
         end

         case (state)
            ST_IDLE: begin
               // Flag drops as LOAD is entered, so an auto-reload pulse
               // covers exactly the INT and IDLE cycles.
               if (ctrl.en) begin
                  irq_flag <= 1'b0;
                  state    <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               count    <= preset;
               presc    <= '0;
               irq_flag <= 1'b0;
               state    <= ST_CNT;
            end

            ST_CNT: begin
               if (!ctrl.en) begin
                  state <= ST_IDLE;
               end else if (presc == PRESC_LAST) begin
                  presc <= '0;
                  if (count > DATA_W'(1)) begin
                     count <= count - DATA_W'(1);
                  end else begin
                     // Saturate at zero; PRESET=0 expires on the first wrap
                     count    <= '0;
                     irq_flag <= 1'b1;
                     state    <= ST_INT;
                  end
               end else begin
                  presc <= presc + PRESC_W'(1);
               end
            end

            ST_INT: begin
               if (ctrl.mode != MODE_RELOAD) begin
                  ctrl.en <= 1'b0;
               end
               state <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase

         // Bus CTRL write is last so it overrides the FSM's EN clear and
         // any flag set in the same cycle.
         if (wr_ctrl_c) begin
            if (byteen[0]) begin
               ctrl <= ctrl_t'(wdata[CTRL_W-1:0]);
            end
            irq_flag <= 1'b0;
         end
      end
   end

   // Read mux
   always_comb begin
      rdata = '0;
      if (sel) begin
         case (addr)
            ADDR_CTRL:   rdata = {{(DATA_W-CTRL_W){1'b0}}, ctrl};
            ADDR_PRESET: rdata = preset;
            ADDR_COUNT:  rdata = count;
            ADDR_RSVD:   rdata = '0;
            default:     rdata = '0;
         endcase
      end
   end

   // Interrupt is a pure function of registered state
   assign irq = ctrl.im & irq_flag;

endmodule : timer_counter

// File: tb/tb_timer_counter.sv
// ---------------------------------------------------------------------------
// tb_timer_counter
// Directed bench: a cycle-by-cycle vector table against a PRESCALE=1
// instance, then hand sequences for prescaled timing (PRESCALE=4 instance)
// and asynchronous reset in the middle of a count.
// ---------------------------------------------------------------------------
module tb_timer_counter;

   localparam logic [1:0] A_CTRL   = 2'd0;
   localparam logic [1:0] A_PRESET = 2'd1;
   localparam logic [1:0] A_COUNT  = 2'd2;
   localparam logic [1:0] A_RSVD   = 2'd3;

   logic        clk;
   logic        reset;
   logic        sel;
   logic        sel4;
   logic [1:0]  addr;
   logic        we;
   logic [3:0]  byteen;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [31:0] rdata4;
   logic        irq;
   logic        irq4;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic        sel;
      logic        we;
      logic [1:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        chk_rd;
      logic [31:0] exp_rd;
      logic        exp_irq;
   } vec_t;

   vec_t vecs[$];

   timer_counter #(.PRESCALE(1)) dut (
      .clk    (clk),
      .reset  (reset),
      .sel    (sel),
      .addr   (addr),
      .we     (we),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (rdata),
      .irq    (irq)
   );

   timer_counter #(.PRESCALE(4)) dut4 (
      .clk    (clk),
      .reset  (reset),
      .sel    (sel4),
      .addr   (addr),
      .we     (we),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (rdata4),
      .irq    (irq4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", what, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic s4, input logic w, input logic [1:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      sel    = s;
      sel4   = s4;
      we     = w;
      addr   = a;
      byteen = b;
      wdata  = d;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic void add(input logic s, input logic w, input logic [1:0] a, input logic [3:0] b,
                               input logic [31:0] d, input logic c, input logic [31:0] e, input logic i);
      vec_t v;
      v.sel = s; v.we = w; v.addr = a; v.be = b; v.wdata = d;
      v.chk_rd = c; v.exp_rd = e; v.exp_irq = i;
      vecs.push_back(v);
   endfunction

   function automatic void rd(input logic [1:0] a, input logic [31:0] e, input logic i);
      add(1'b1, 1'b0, a, 4'h0, 32'h0, 1'b1, e, i);
   endfunction

   function automatic void wr(input logic [1:0] a, input logic [3:0] b, input logic [31:0] d, input logic i);
      add(1'b1, 1'b1, a, b, d, 1'b0, 32'h0, i);
   endfunction

   initial begin
      int found;
      int exp_cnt;

      // ---------------- vector table (PRESCALE=1 instance) ----------------
      // One-shot countdown from 5 with IM=1
      rd(A_CTRL, 0, 0); rd(A_PRESET, 0, 0); rd(A_COUNT, 0, 0);
      wr(A_PRESET, 4'hF, 32'd5, 0); wr(A_CTRL, 4'hF, 32'h9, 0);
      rd(A_COUNT, 0, 0); rd(A_COUNT, 0, 0);                       // IDLE, LOAD
      rd(A_COUNT, 5, 0); rd(A_COUNT, 4, 0); rd(A_COUNT, 3, 0);
      rd(A_COUNT, 2, 0); rd(A_COUNT, 1, 0);
      rd(A_COUNT, 0, 1); rd(A_CTRL, 32'h8, 1); rd(A_COUNT, 0, 1);
      // IM=0 expiry keeps irq low; later IM=1 write clears the flag
      wr(A_PRESET, 4'hF, 32'd1, 1); wr(A_CTRL, 4'hF, 32'h1, 1);
      rd(A_CTRL, 32'h1, 0); rd(A_COUNT, 0, 0); rd(A_COUNT, 1, 0);
      rd(A_CTRL, 32'h1, 0); rd(A_CTRL, 32'h0, 0);
      wr(A_CTRL, 4'hF, 32'h8, 0); rd(A_CTRL, 32'h8, 0);
      // Auto-reload, PRESET=3: 2-cycle irq pulse every 6 cycles
      wr(A_PRESET, 4'hF, 32'd3, 0); wr(A_CTRL, 4'hF, 32'hB, 0);
      rd(A_COUNT, 0, 0); rd(A_COUNT, 0, 0);
      rd(A_COUNT, 3, 0); rd(A_COUNT, 2, 0); rd(A_COUNT, 1, 0);
      rd(A_COUNT, 0, 1); rd(A_COUNT, 0, 1); rd(A_COUNT, 0, 0);
      rd(A_COUNT, 3, 0); rd(A_COUNT, 2, 0); rd(A_COUNT, 1, 0);
      rd(A_COUNT, 0, 1); rd(A_COUNT, 0, 1); rd(A_COUNT, 0, 0);
      rd(A_CTRL, 32'hB, 0);
      // EN=0 write lands one cycle late: one more decrement, then hold
      wr(A_CTRL, 4'hF, 32'h0, 0); rd(A_COUNT, 1, 0); rd(A_COUNT, 1, 0);
      // PRESET byte write mid-count, COUNT write ignored
      wr(A_PRESET, 4'hF, 32'd13, 0); wr(A_CTRL, 4'hF, 32'h1, 0);
      rd(A_COUNT, 1, 0); rd(A_COUNT, 1, 0);
      wr(A_PRESET, 4'hF, 32'h0, 0); rd(A_COUNT, 12, 0); rd(A_COUNT, 11, 0);
      wr(A_PRESET, 4'b0010, 32'hAAAA_0155, 0);
      rd(A_PRESET, 32'h100, 0);
      wr(A_COUNT, 4'hF, 32'hFFFF_FFFF, 0); rd(A_COUNT, 7, 0);
      wr(A_CTRL, 4'hF, 32'h0, 0); rd(A_COUNT, 5, 0); rd(A_COUNT, 5, 0);
      // Reserved word, deselected read, deselected write
      rd(A_RSVD, 0, 0);
      add(1'b0, 1'b0, A_COUNT, 4'h0, 32'h0, 1'b1, 32'h0, 1'b0);
      add(1'b0, 1'b1, A_PRESET, 4'hF, 32'h77, 1'b1, 32'h0, 1'b0);
      rd(A_PRESET, 32'h100, 0);
      // CTRL upper bits ignored; CTRL byte 0 masked off
      wr(A_CTRL, 4'hF, 32'hFFFF_FFF8, 0); rd(A_CTRL, 32'h8, 0);
      wr(A_CTRL, 4'b1110, 32'h9, 0); rd(A_CTRL, 32'h8, 0);
      // PRESET=0 expires on the first prescaler wrap
      wr(A_PRESET, 4'hF, 32'h0, 0); wr(A_CTRL, 4'hF, 32'h9, 0);
      rd(A_COUNT, 5, 0); rd(A_COUNT, 5, 0);
      rd(A_COUNT, 0, 0); rd(A_COUNT, 0, 1); rd(A_CTRL, 32'h8, 1);
      // CTRL write in INT beats the FSM's EN clear
      wr(A_CTRL, 4'hF, 32'h9, 1); rd(A_COUNT, 0, 0); rd(A_COUNT, 0, 0);
      rd(A_COUNT, 0, 0);
      wr(A_CTRL, 4'hF, 32'hB, 1); rd(A_CTRL, 32'hB, 0);
      wr(A_CTRL, 4'hF, 32'h0, 0); rd(A_CTRL, 32'h0, 0); rd(A_CTRL, 32'h0, 0);

      // ---------------- reset ----------------
      reset = 1'b0;
      drive(1'b1, 1'b1, 1'b0, A_CTRL, 4'h0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      check("reset_ctrl", rdata, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      addr = A_COUNT;
      #1;
      check("reset_count4", rdata4, 32'h0);
      #1 reset = 1'b1;
      next_cycle();

      // ---------------- apply table ----------------
      foreach (vecs[i]) begin
         drive(vecs[i].sel, 1'b0, vecs[i].we, vecs[i].addr, vecs[i].be, vecs[i].wdata);
         @(negedge clk);
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
         check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
         next_cycle();
      end

      // ---------------- PRESCALE=4: COUNT steps every 4th cycle ----------------
      drive(1'b0, 1'b1, 1'b1, A_PRESET, 4'hF, 32'd2);
      next_cycle();
      drive(1'b0, 1'b1, 1'b1, A_CTRL, 4'hF, 32'h9);
      next_cycle();
      drive(1'b0, 1'b1, 1'b0, A_COUNT, 4'h0, 32'h0);
      // k=0 IDLE, k=1 LOAD, k=2 first CNT cycle; irq 8 cycles later
      for (int k = 0; k < 13; k++) begin
         exp_cnt = (k < 2) ? 0 : (k < 6) ? 2 : (k < 10) ? 1 : 0;
         @(negedge clk);
         check($sformatf("p4_count_k%0d", k), rdata4, 32'(exp_cnt));
         check($sformatf("p4_irq_k%0d", k), {31'h0, irq4}, {31'h0, (k >= 10)});
         next_cycle();
      end

      // ---------------- async reset mid-count ----------------
      drive(1'b1, 1'b0, 1'b1, A_PRESET, 4'hF, 32'd20);
      next_cycle();
      drive(1'b1, 1'b0, 1'b1, A_CTRL, 4'hF, 32'h9);
      next_cycle();
      drive(1'b1, 1'b0, 1'b0, A_COUNT, 4'h0, 32'h0);
      found = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (rdata == 32'd7) begin
            found = 1;
            break;
         end
         next_cycle();
      end
      check("rst_reach_count7", 32'(found), 32'd1);
      #1 reset = 1'b0;
      #1 check("rst_async_count", rdata, 32'h0);
      check("rst_async_irq", {31'h0, irq}, 32'h0);
      addr = A_CTRL;
      #1 check("rst_async_ctrl", rdata, 32'h0);
      addr = A_PRESET;
      #1 check("rst_async_preset", rdata, 32'h0);
      @(negedge clk);
      #1 reset = 1'b1;
      addr = A_COUNT;
      next_cycle();
      // No EN after reset: stays idle at zero
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check($sformatf("rst_idle_count_k%0d", k), rdata, 32'h0);
         check($sformatf("rst_idle_irq_k%0d", k), {31'h0, irq}, 32'h0);
         next_cycle();
      end
      // New EN write restarts counting
      drive(1'b1, 1'b0, 1'b1, A_PRESET, 4'hF, 32'd2);
      next_cycle();
      drive(1'b1, 1'b0, 1'b1, A_CTRL, 4'hF, 32'h1);
      next_cycle();
      drive(1'b1, 1'b0, 1'b0, A_COUNT, 4'h0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         exp_cnt = (k < 2) ? 0 : (k == 2) ? 2 : 1;
         @(negedge clk);
         check($sformatf("rst_resume_k%0d", k), rdata, 32'(exp_cnt));
         next_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_timer_counter
